// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding
// and a constant clog2 helper used to size the bit counter.
package serial_subtractor_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake bundle for the serial subtractor.
// master: drives start/a0/a1/bi; slave: drives busy/done/diff/bo.
interface serial_subtractor_if #(
    parameter int N = 16
);
    logic         start;
    logic [N-1:0] a0;
    logic [N-1:0] a1;
    logic         bi;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         bo;

    modport master (
        output start, a0, a1, bi,
        input  busy, done, diff, bo
    );

    modport slave (
        input  start, a0, a1, bi,
        output busy, done, diff, bo
    );
endinterface

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor built from gate primitives.
// Ports: x - y - b -> difference d, borrow-out bo.
module full_subtractor_cell (
    input  wire x,
    input  wire y,
    input  wire b,
    output wire d,
    output wire bo
);
    wire xy_x;
    wire nx;
    wire nxy;
    wire t0;
    wire t1;

    xor g_x0 (xy_x, x, y);
    xor g_x1 (d, xy_x, b);
    not g_n0 (nx, x);
    and g_a0 (t0, nx, y);
    not g_n1 (nxy, xy_x);
    and g_a1 (t1, nxy, b);
    or  g_o0 (bo, t0, t1);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a0 - a1 - bi, one bit per clock, LSB first.
// Ports: clock, reset (async, active high), bus (slave side of handshake).
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int N = 16
) (
    input logic          clock,
    input logic          reset,
    serial_subtractor_if.slave bus
);
    localparam int CW = clog2(N);

    state_t       state_q;
    logic [N-1:0] x_q;
    logic [N-1:0] y_q;
    logic [N-1:0] res_q;
    logic [N-1:0] res_d;
    logic         b_q;
    logic [CW-1:0] cnt_q;
    logic         busy_q;
    logic         done_q;
    logic [N-1:0] diff_q;
    logic         bo_q;
    logic         d_w;
    logic         bn_w;

    // Operands shift right, so bit 0 always holds the bit under work.
    full_subtractor_cell u_cell (
        .x  (x_q[0]),
        .y  (y_q[0]),
        .b  (b_q),
        .d  (d_w),
        .bo (bn_w)
    );

    // New bit enters at the MSB; after N shifts the LSB lands at bit 0.
    assign res_d = {d_w, res_q[N-1:1]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            res_q   <= '0;
            b_q     <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bo_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        x_q     <= bus.a0;
                        y_q     <= bus.a1;
                        b_q     <= bus.bi;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    x_q   <= x_q >> 1;
                    y_q   <= y_q >> 1;
                    b_q   <= bn_w;
                    res_q <= res_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) begin
                        diff_q  <= res_d;
                        bo_q    <= bn_w;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bo   = bo_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor (N=16 and N=4 builds)
// using an expected-result queue filled at issue, drained at done.
module tb_serial_subtractor;
    logic clock = 1'b0;
    logic reset = 1'b1;

    serial_subtractor_if #(.N(16)) bus16 ();
    serial_subtractor_if #(.N(4))  bus4 ();

    serial_subtractor #(.N(16)) dut16 (
        .clock (clock),
        .reset (reset),
        .bus   (bus16)
    );

    serial_subtractor #(.N(4)) dut4 (
        .clock (clock),
        .reset (reset),
        .bus   (bus4)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic [16:0] sb[$];
    logic [15:0] prev_diff = 16'h0;
    logic        prev_bo = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] model(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic c);
        return {1'b0, a} - {1'b0, b} - {16'h0, c};
    endfunction

    // Called at a negedge with the DUT idle; returns one negedge later.
    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic c);
        bus16.start = 1'b1;
        bus16.a0    = a;
        bus16.a1    = b;
        bus16.bi    = c;
        sb.push_back(model(a, b, c));
        @(negedge clock);
        bus16.start = 1'b0;
    endtask

    // Returns at the negedge where done is high (or after the bound).
    task automatic wait_done(input string tag, input bit chk_busy,
                             input bit scramble);
        int busy_cnt;
        int guard;
        bit stable;
        logic [16:0] exp;
        busy_cnt = 0;
        guard = 0;
        stable = 1'b1;
        while (bus16.done !== 1'b1 && guard < 40) begin
            if (bus16.busy === 1'b1) busy_cnt++;
            if (bus16.diff !== prev_diff || bus16.bo !== prev_bo)
                stable = 1'b0;
            if (scramble) begin
                bus16.a0 = 16'($urandom);
                bus16.a1 = 16'($urandom);
                bus16.bi = 1'($urandom);
            end
            @(negedge clock);
            guard++;
        end
        check({tag, " done"}, 32'(bus16.done), 32'd1);
        exp = (sb.size() > 0) ? sb.pop_front() : 17'h0;
        check({tag, " diff"}, 32'(bus16.diff), 32'(exp[15:0]));
        check({tag, " bo"}, 32'(bus16.bo), 32'(exp[16]));
        check({tag, " hold"}, 32'(stable), 32'd1);
        if (chk_busy) check({tag, " busy cycles"}, busy_cnt, 16);
        prev_diff = exp[15:0];
        prev_bo   = exp[16];
    endtask

    initial begin
        int seen;
        int cnt;
        logic [4:0] e4;
        logic [3:0] ra;
        logic [3:0] rb;
        logic       rc;

        bus16.start = 1'b0;
        bus16.a0 = '0;
        bus16.a1 = '0;
        bus16.bi = 1'b0;
        bus4.start = 1'b0;
        bus4.a0 = '0;
        bus4.a1 = '0;
        bus4.bi = 1'b0;

        repeat (2) @(negedge clock);
        check("rst busy", 32'(bus16.busy), 0);
        check("rst done", 32'(bus16.done), 0);
        check("rst diff", 32'(bus16.diff), 0);
        check("rst bo", 32'(bus16.bo), 0);
        reset = 1'b0;
        @(negedge clock);

        issue(16'h1234, 16'h0034, 1'b0);
        check("basic busy", 32'(bus16.busy), 1);
        wait_done("basic", 1'b1, 1'b0);
        @(negedge clock);
        check("basic done pulse", 32'(bus16.done), 0);
        check("basic diff hold", 32'(bus16.diff), 32'h1200);

        issue(16'h0000, 16'h0001, 1'b0);
        wait_done("underflow", 1'b1, 1'b0);
        @(negedge clock);
        issue(16'h8000, 16'h8000, 1'b1);
        wait_done("borrow-in", 1'b1, 1'b0);
        @(negedge clock);

        issue(16'h1234, 16'h0034, 1'b0);
        repeat (4) @(negedge clock);
        bus16.start = 1'b1;
        bus16.a0 = 16'hFFFF;
        bus16.a1 = 16'h0000;
        bus16.bi = 1'b0;
        @(negedge clock);
        bus16.start = 1'b0;
        check("ignored busy", 32'(bus16.busy), 1);
        wait_done("ignored", 1'b0, 1'b0);
        issue(16'h0010, 16'h0001, 1'b0);
        wait_done("b2b", 1'b1, 1'b0);
        @(negedge clock);
        check("b2b idle busy", 32'(bus16.busy), 0);
        check("b2b idle done", 32'(bus16.done), 0);

        issue(16'h1234, 16'h0034, 1'b0);
        repeat (7) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("abort busy", 32'(bus16.busy), 0);
        check("abort done", 32'(bus16.done), 0);
        check("abort diff", 32'(bus16.diff), 0);
        check("abort bo", 32'(bus16.bo), 0);
        sb.delete();
        prev_diff = 16'h0;
        prev_bo = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clock);
            if (bus16.done === 1'b1) seen++;
        end
        check("abort no done", seen, 0);
        issue(16'h00FF, 16'h000F, 1'b0);
        wait_done("after abort", 1'b1, 1'b0);
        @(negedge clock);

        issue(16'hA5A5, 16'h1111, 1'b1);
        wait_done("scramble", 1'b1, 1'b1);
        bus16.a0 = '0;
        bus16.a1 = '0;
        bus16.bi = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 1000; i++) begin
            issue(16'($urandom), 16'($urandom), 1'($urandom));
            wait_done("rand", 1'b0, 1'b0);
            if ($urandom_range(0, 3) == 0) @(negedge clock);
        end
        @(negedge clock);

        for (int i = 0; i < 21; i++) begin
            if (i == 0) begin
                ra = 4'h5;
                rb = 4'h7;
                rc = 1'b0;
            end else begin
                ra = 4'($urandom);
                rb = 4'($urandom);
                rc = 1'($urandom);
            end
            e4 = {1'b0, ra} - {1'b0, rb} - {4'h0, rc};
            bus4.start = 1'b1;
            bus4.a0 = ra;
            bus4.a1 = rb;
            bus4.bi = rc;
            @(negedge clock);
            bus4.start = 1'b0;
            cnt = 0;
            while (bus4.done !== 1'b1 && cnt < 20) begin
                @(negedge clock);
                cnt++;
            end
            check("n4 latency", cnt, 4);
            check("n4 diff", 32'(bus4.diff), 32'(e4[3:0]));
            check("n4 bo", 32'(bus4.bo), 32'(e4[4]));
            @(negedge clock);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
